// File: rtl/vga_timing_pkg.sv
// Shared raster timing defaults and coordinate type
// for the VGA timing generator and its axis counters.
package vga_timing_pkg;

  localparam int COORD_W = 10;

  typedef logic [COORD_W-1:0] coord_t;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;

  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;

  localparam int DEF_H_TOTAL =
    DEF_H_VISIBLE + DEF_H_FP +
    DEF_H_SYNC + DEF_H_BP;

  localparam int DEF_V_TOTAL =
    DEF_V_VISIBLE + DEF_V_FP +
    DEF_V_SYNC + DEF_V_BP;

  function automatic bit fits_coord(
    input int total
  );
    return (total > 0) &&
           (total <= (1 << COORD_W));
  endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Raster outputs bundle: coordinates, syncs,
// display enable and frame pacing signals.
interface vga_timing_if;
  import vga_timing_pkg::*;

  coord_t      DrawX;
  coord_t      DrawY;
  logic        hs;
  logic        vs;
  logic        blank;
  logic        sync;
  logic        frame_start;
  logic        vblank_start;
  logic [15:0] frame_count;

  modport master (
    output DrawX,
    output DrawY,
    output hs,
    output vs,
    output blank,
    output sync,
    output frame_start,
    output vblank_start,
    output frame_count
  );

  modport slave (
    input DrawX,
    input DrawY,
    input hs,
    input vs,
    input blank,
    input sync,
    input frame_start,
    input vblank_start,
    input frame_count
  );

endinterface

// File: rtl/vga_sync_axis.sv
// One raster axis: wrapping counter with enable,
// terminal count and registered sync decode.
module vga_sync_axis
  import vga_timing_pkg::*;
#(
  parameter int VISIBLE = DEF_H_VISIBLE,
  parameter int FP      = DEF_H_FP,
  parameter int SYNC    = DEF_H_SYNC,
  parameter int BP      = DEF_H_BP
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  output coord_t count,
  output coord_t count_nxt,
  output logic   tc,
  output logic   active_nxt,
  output logic   sync_n
);

  localparam int TOTAL = VISIBLE + FP + SYNC + BP;
  localparam int S_LO  = VISIBLE + FP;
  localparam int S_HI  = S_LO + SYNC;

  localparam coord_t LAST = coord_t'(TOTAL - 1);

  if (!fits_coord(TOTAL)) begin : g_bad_total
    $error("vga_sync_axis: total %0d too wide",
           TOTAL);
  end

  logic in_sync;

  assign tc = (count == LAST);

  always_comb begin
    count_nxt = count;
    if (en) begin
      count_nxt = tc ? '0 : count + coord_t'(1);
    end
  end

  // Decode from the next count so the registered
  // sync lines up with the registered count.
  assign active_nxt = int'(count_nxt) < VISIBLE;

  assign in_sync = (int'(count_nxt) >= S_LO) &&
                   (int'(count_nxt) <  S_HI);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      sync_n <= 1'b1;
    end else begin
      count  <= count_nxt;
      sync_n <= !in_sync;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster generator: coordinates,
// syncs, display enable and frame pacing outputs.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP
) (
  input  logic         vga_clk,
  input  logic         reset,
  vga_timing_if.master vga
);

  coord_t hc;
  coord_t hc_nxt;
  coord_t vc;
  coord_t vc_nxt;

  logic h_tc;
  logic v_tc;
  logic h_act;
  logic v_act;
  logic hs_n;
  logic vs_n;

  logic        blank_q;
  logic        fs_q;
  logic        vbs_q;
  logic [15:0] fc_q;

  vga_sync_axis #(
    .VISIBLE (H_VISIBLE),
    .FP      (H_FP),
    .SYNC    (H_SYNC),
    .BP      (H_BP)
  ) u_h_axis (
    .clk        (vga_clk),
    .rst        (reset),
    .en         (1'b1),
    .count      (hc),
    .count_nxt  (hc_nxt),
    .tc         (h_tc),
    .active_nxt (h_act),
    .sync_n     (hs_n)
  );

  // Vertical steps on the same edge hc wraps.
  vga_sync_axis #(
    .VISIBLE (V_VISIBLE),
    .FP      (V_FP),
    .SYNC    (V_SYNC),
    .BP      (V_BP)
  ) u_v_axis (
    .clk        (vga_clk),
    .rst        (reset),
    .en         (h_tc),
    .count      (vc),
    .count_nxt  (vc_nxt),
    .tc         (v_tc),
    .active_nxt (v_act),
    .sync_n     (vs_n)
  );

  // Reset state is pixel (0,0) of a fresh frame.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      blank_q <= 1'b1;
      fs_q    <= 1'b1;
      vbs_q   <= 1'b0;
      fc_q    <= '0;
    end else begin
      blank_q <= h_act && v_act;
      fs_q    <= (hc_nxt == '0) && (vc_nxt == '0);
      vbs_q   <= (hc_nxt == '0) &&
                 (int'(vc_nxt) == V_VISIBLE);
      if (h_tc && v_tc) begin
        fc_q <= fc_q + 16'd1;
      end
    end
  end

  assign vga.DrawX        = hc;
  assign vga.DrawY        = vc;
  assign vga.hs           = hs_n;
  assign vga.vs           = vs_n;
  assign vga.blank        = blank_q;
  assign vga.sync         = 1'b0;
  assign vga.frame_start  = fs_q;
  assign vga.vblank_start = vbs_q;
  assign vga.frame_count  = fc_q;

endmodule
